// File: rtl/lj16_to_i2s_if.sv
// lj16_to_i2s_if: serial audio bundle for the 16LJ to I2S converter.
// The source side drives the 16LJ lines, the converter drives I2S and status.
interface lj16_to_i2s_if;
  logic lj_bck;
  logic lj_data;
  logic lj_lrck;
  logic i2s_data;
  logic i2s_lrck;
  logic locked;
  logic resync;

  modport master (
    output lj_bck, lj_data, lj_lrck,
    input  i2s_data, i2s_lrck, locked, resync
  );

  modport slave (
    input  lj_bck, lj_data, lj_lrck,
    output i2s_data, i2s_lrck, locked, resync
  );
endinterface

// File: rtl/lj16_to_i2s.sv
// lj16_to_i2s: 16-bit left-justified (32fs) to I2S (64fs) re-framer.
// Words are double-buffered into a free-running 64-bit output frame.
module lj16_to_i2s #(
  parameter int LOCK_TIMEOUT = 128
) (
  input logic          bck,
  input logic          rst,
  lj16_to_i2s_if.slave bus
);

  localparam logic [7:0] WD_LIMIT =
    (LOCK_TIMEOUT > 255) ? 8'hFF : LOCK_TIMEOUT[7:0];
  localparam logic [5:0] CNT_LAST = 6'd63;

  logic        ljbck_q;
  logic        lrck_q, lrck_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic        done_q, done_d;
  logic [14:0] shift_q, shift_d;
  logic [15:0] hold_l_q, hold_l_d;
  logic [15:0] hold_r_q, hold_r_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [7:0]  wd_q, wd_d;
  logic        locked_q, locked_d;
  logic        resync_q, resync_d;
  logic [15:0] out_l_q, out_l_d;
  logic [15:0] out_r_q, out_r_d;
  logic        data_q, data_d;

  logic        smp;
  logic        ch_start;
  logic        left_start;
  logic [15:0] word;
  logic [4:0]  p;
  logic [3:0]  idx;
  logic [15:0] sel;
  logic        in_slot;

  assign smp        = bus.lj_bck & ~ljbck_q;
  assign ch_start   = smp & (bus.lj_lrck ^ lrck_q);
  assign left_start = ch_start & bus.lj_lrck;
  assign word       = {shift_q, bus.lj_data};

  // Word assembly: first 15 bits shift in, the 16th completes the word.
  // A channel start throws away any partial word; extra bits are ignored.
  always_comb begin
    lrck_d   = lrck_q;
    bitcnt_d = bitcnt_q;
    done_d   = done_q;
    shift_d  = shift_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    if (ch_start) begin
      lrck_d   = bus.lj_lrck;
      bitcnt_d = 4'd0;
      done_d   = 1'b0;
      shift_d  = {14'd0, bus.lj_data};
    end else if (smp && !done_q) begin
      bitcnt_d = bitcnt_q + 4'd1;
      shift_d  = word[14:0];
      if (bitcnt_q == 4'd14) begin
        done_d = 1'b1;
        if (lrck_q) hold_l_d = word;
        else        hold_r_d = word;
      end
    end
  end

  // Framing, lock tracking and the serialised output bit for the next cycle.
  always_comb begin
    cnt_d    = cnt_q + 6'd1;
    locked_d = locked_q;
    resync_d = 1'b0;
    wd_d     = (wd_q == 8'hFF) ? wd_q : wd_q + 8'd1;
    if (left_start) begin
      wd_d     = 8'd0;
      locked_d = 1'b1;
      if (cnt_q != CNT_LAST) begin
        cnt_d    = 6'd0;
        resync_d = locked_q;
      end
    end else if (locked_q && wd_d == WD_LIMIT) begin
      locked_d = 1'b0;
    end

    out_l_d = out_l_q;
    out_r_d = out_r_q;
    if (cnt_d == 6'd0) begin
      out_l_d = hold_l_q;
      out_r_d = hold_r_q;
    end

    // Slot position p=1..16 maps to bit 16-p, i.e. -p modulo 16.
    p       = cnt_d[4:0];
    idx     = 4'd0 - p[3:0];
    sel     = cnt_d[5] ? out_r_d : out_l_d;
    in_slot = (p != 5'd0) && (p <= 5'd16);
    data_d  = locked_d && in_slot && sel[idx];
  end

  // State registers.
  always_ff @(posedge bck or posedge rst) begin
    if (rst) begin
      ljbck_q  <= 1'b0;
      lrck_q   <= 1'b0;
      bitcnt_q <= 4'd0;
      done_q   <= 1'b1;
      shift_q  <= 15'd0;
      hold_l_q <= 16'd0;
      hold_r_q <= 16'd0;
      cnt_q    <= 6'd0;
      wd_q     <= 8'd0;
      locked_q <= 1'b0;
      resync_q <= 1'b0;
      out_l_q  <= 16'd0;
      out_r_q  <= 16'd0;
      data_q   <= 1'b0;
    end else begin
      ljbck_q  <= bus.lj_bck;
      lrck_q   <= lrck_d;
      bitcnt_q <= bitcnt_d;
      done_q   <= done_d;
      shift_q  <= shift_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      locked_q <= locked_d;
      resync_q <= resync_d;
      out_l_q  <= out_l_d;
      out_r_q  <= out_r_d;
      data_q   <= data_d;
    end
  end

  assign bus.i2s_data = data_q;
  assign bus.i2s_lrck = cnt_q[5];
  assign bus.locked   = locked_q;
  assign bus.resync   = resync_q;

endmodule

// File: tb/tb_lj16_to_i2s.sv
// tb_lj16_to_i2s: drives 16LJ pairs, decodes the I2S frames and
// compares each decoded frame against a queue of expected pairs.
module tb_lj16_to_i2s;

  logic bck = 1'b0;
  logic rst = 1'b1;
  lj16_to_i2s_if bus ();

  lj16_to_i2s #(.LOCK_TIMEOUT(128)) dut (
    .bck (bck),
    .rst (rst),
    .bus (bus)
  );

  always #5 bck = ~bck;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int nres = 0;
  int last_ls = 0;
  logic [15:0] last_r = 16'd0;
  logic [31:0] sb[$];

  logic [5:0]  mc = 6'd0;
  logic [5:0]  lmc = 6'd0;
  logic        f_ok = 1'b0;
  logic        pl = 1'b0;
  logic        pk = 1'b0;
  logic        pad_bad = 1'b0;
  logic [15:0] wl = 16'd0;
  logic [15:0] wr = 16'd0;

  always @(posedge bck) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // One 16LJ bit: lj_bck low half then high half; DUT samples at the
  // posedge that ends the high half.
  task automatic lj_slot(input logic lr, input logic d);
    @(posedge bck);
    #1;
    bus.lj_bck  = 1'b0;
    bus.lj_lrck = lr;
    bus.lj_data = d;
    @(posedge bck);
    #1;
    bus.lj_bck = 1'b1;
  endtask

  task automatic send_pair(input logic [15:0] l, input logic [15:0] r,
                           input int rlen, input int pad,
                           input bit chk_lock, input bit chk63);
    logic [31:0] e;
    if (rlen >= 16) begin
      e = {l, r};
      last_r = r;
    end else begin
      // Early left start truncates the frame carrying the previous pair.
      e = {l, last_r};
      if (sb.size() > 0) void'(sb.pop_back());
    end
    sb.push_back(e);
    lj_slot(1'b1, l[15]);
    last_ls = cyc + 1;
    if (chk_lock) begin
      chk("lock_pre", {31'd0, bus.locked}, 0);
      fork
        begin
          @(posedge bck);
          @(negedge bck);
          chk("lock_acq", {31'd0, bus.locked}, 1);
          chk("resync_acq", {31'd0, bus.resync}, 0);
        end
      join_none
    end
    if (chk63) begin
      @(negedge bck);
      #1;
      chk("ls_at63", {26'd0, mc}, 63);
    end
    for (int i = 14; i >= 0; i--) lj_slot(1'b1, l[i]);
    for (int i = 0; i < rlen; i++) lj_slot(1'b0, r[15-i]);
    for (int i = 0; i < pad; i++) lj_slot(1'b0, 1'b0);
  endtask

  // Output monitor: own frame position, aligned on lrck fall, resync
  // and lock rise; complete locked frames are checked against the queue.
  initial begin
    logic [31:0] e;
    int pp;
    forever begin
      @(negedge bck);
      if (rst) begin
        mc = 6'd0;
        lmc = 6'd0;
        f_ok = 1'b0;
        pl = 1'b0;
        pk = 1'b0;
      end else begin
        if (bus.resync) nres++;
        if (bus.resync || (pl && !bus.i2s_lrck) || (bus.locked && !pk))
          mc = 6'd0;
        else
          mc = mc + 6'd1;
        if (mc == 6'd0) begin
          if (f_ok && lmc == 6'd63) begin
            chk("sb_avail", {31'd0, sb.size() > 0}, 1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              chk("left", {16'd0, wl}, {16'd0, e[31:16]});
              chk("right", {16'd0, wr}, {16'd0, e[15:0]});
              chk("pad", {31'd0, pad_bad}, 0);
            end
          end
          f_ok = bus.locked && pk;
          wl = 16'd0;
          wr = 16'd0;
          pad_bad = 1'b0;
        end
        if (!bus.locked) f_ok = 1'b0;
        if (f_ok) chk("lrck", {31'd0, bus.i2s_lrck}, {31'd0, mc[5]});
        pp = int'(mc[4:0]);
        if (pp >= 1 && pp <= 16) begin
          if (mc[5]) wr[16-pp] = bus.i2s_data;
          else       wl[16-pp] = bus.i2s_data;
        end else if (bus.i2s_data !== 1'b0) begin
          pad_bad = 1'b1;
        end
        lmc = mc;
        pl = bus.i2s_lrck;
        pk = bus.locked;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ones;
    int tog;
    logic lp;
    logic [15:0] pl_l;
    bus.lj_bck = 1'b0;
    bus.lj_data = 1'b0;
    bus.lj_lrck = 1'b0;
    repeat (3) @(negedge bck);
    chk("rst_outs",
        {28'd0, bus.i2s_data, bus.i2s_lrck, bus.locked, bus.resync}, 0);
    #1 rst = 1'b0;
    repeat (3) lj_slot(1'b0, 1'b0);

    for (int k = 0; k < 12; k++)
      send_pair(16'hA5C3, 16'h0F0F, 16, 0, k == 0, k >= 1);
    chk("resync_steady", nres, 0);

    send_pair(16'hA5C3, 16'h0F0F, 16, 1, 1'b0, 1'b1);
    send_pair(16'hC3A5, 16'hF00F, 16, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      send_pair(16'hA5C3, 16'h0F0F, 16, 0, 1'b0, 1'b1);
    chk("resync_shift", nres, 1);
    chk("lock_shift", {31'd0, bus.locked}, 1);

    send_pair(16'h3C5A, 16'h1234, 10, 0, 1'b0, 1'b1);
    send_pair(16'hA5C3, 16'h0F0F, 16, 0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      send_pair(16'h8001, 16'h7FFE, 16, 0, 1'b0, 1'b1);
    chk("resync_short", nres, 2);

    while (cyc != last_ls + 127) @(negedge bck);
    chk("wd_hold", {31'd0, bus.locked}, 1);
    @(negedge bck);
    chk("wd_drop", {31'd0, bus.locked}, 0);
    ones = 0;
    tog = 0;
    lp = bus.i2s_lrck;
    repeat (128) begin
      @(negedge bck);
      if (bus.i2s_data !== 1'b0) ones++;
      if (bus.i2s_lrck !== lp) tog++;
      lp = bus.i2s_lrck;
    end
    chk("wd_data", ones, 0);
    chk("wd_lrck_tog", tog, 4);
    chk("sb_drain1", sb.size(), 0);

    send_pair(16'hA5C3, 16'h0F0F, 16, 0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      send_pair(16'hA5C3, 16'h0F0F, 16, 0, 1'b0, 1'b1);
    pl_l = 16'h5555;
    for (int i = 15; i >= 5; i--) lj_slot(1'b1, pl_l[i]);
    @(posedge bck);
    #1;
    bus.lj_bck = 1'b0;
    @(negedge bck);
    #1;
    chk("rst_at20", {26'd0, mc}, 20);
    rst = 1'b1;
    #1;
    chk("rst_async",
        {28'd0, bus.i2s_data, bus.i2s_lrck, bus.locked, bus.resync}, 0);
    bus.lj_lrck = 1'b0;
    bus.lj_data = 1'b0;
    sb.delete();
    repeat (4) begin
      @(negedge bck);
      chk("rst_hold",
          {28'd0, bus.i2s_data, bus.i2s_lrck, bus.locked, bus.resync}, 0);
    end
    #1 rst = 1'b0;
    repeat (2) lj_slot(1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      send_pair(16'h1234, 16'hFEDC, 16, 0, k == 0, k >= 1);
    repeat (140) @(negedge bck);
    chk("sb_drain2", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lj16_to_i2s.md
LJ16_TO_I2S -- requirements
Module: lj16_to_i2s

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 128: bck cycles without a left-channel start before lock is dropped.
REQ-002 SHALL have port bck, input, 1: single clock, 64fs I2S bit clock; all logic on posedge bck.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port lj_bck, input, 1: 16LJ bit clock at 32fs, synchronous to bck (bck/2).
REQ-005 SHALL have port lj_data, input, 1: 16LJ serial data, MSB first, 16 bits per channel, no padding.
REQ-006 SHALL have port lj_lrck, input, 1: 16LJ word clock; high = left, low = right.
REQ-007 SHALL have port i2s_data, output, 1: I2S serial data, flop-driven; downstream samples on negedge bck.
REQ-008 SHALL have port i2s_lrck, output, 1: I2S word clock; low = left slot, high = right slot.
REQ-009 SHALL have port locked, output, 1: high while output framing is aligned to the input.
REQ-010 SHALL have port resync, output, 1: one-cycle pulse on any re-alignment while locked.

Function
REQ-011 Input sample point: a cycle in which lj_bck is 1 and its registered previous value is 0; lj_data and lj_lrck are captured only there.
REQ-012 Channel start: captured lj_lrck differs from the previous captured lj_lrck; the captured bit is the MSB of the new word and the 4-bit bit counter restarts at 0.
REQ-013 Left start: a channel start where captured lj_lrck = 1.
REQ-014 Word assembly: a 16-bit shift register, MSB first; on the 16th captured bit the word loads into hold_l (lrck=1) or hold_r (lrck=0).
REQ-015 Short word (channel start before 16 bits): discard the partial word; the hold register keeps its old value.
REQ-016 Long word: bits after the 16th and before the next channel start are ignored.
REQ-017 Output frame counter: 6 bits, free-running, increments every bck, 63 wraps to 0.
REQ-018 On the edge where the counter goes to 0: out_l <= hold_l and out_r <= hold_r (double buffer). The hold registers may update at any time without corrupting the frame in flight.
REQ-019 With counter = c: i2s_lrck = c[5]; p = c[4:0]; i2s_data = 0 at p=0, out_x[16-p] at p=1..16 (MSB at p=1, I2S one-bit delay), 0 at p=17..31; out_x is out_l when c[5]=0, else out_r.
REQ-020 Unlocked: the counter still free-runs, i2s_lrck toggles per REQ-019, i2s_data is forced 0.
REQ-021 Lock acquire: a left start while unlocked sets counter <= 0 and locked <= 1 on the next edge; no resync pulse.
REQ-022 Locked, left start with counter = 63: nominal, no action.
REQ-023 Locked, left start with counter != 63: counter <= 0, resync = 1 for one cycle, locked stays 1.
REQ-024 Watchdog: an 8-bit counter cleared on every left start, incremented otherwise, saturating. Reaching LOCK_TIMEOUT while locked sets locked <= 0.
REQ-025 Simultaneous watchdog expiry and left start: the left start wins; the watchdog is cleared and lock is kept.
REQ-026 Latency: a stereo pair whose right word completes in output frame N appears in frame N+1. Left MSB is on i2s_data at counter = 1 of that frame.

Reset
REQ-027 While rst=1, and immediately on assertion: i2s_data=0, i2s_lrck=0, locked=0, resync=0; counter, bit counter, watchdog, shift/hold/out registers = 0; previous lj_bck and lj_lrck captures = 0.
REQ-028 Reset mid-frame aborts all words in progress; after release the block behaves as from power-up and requires a new left start to lock.

Verification
REQ-029 Reset release, then a 16LJ stream L=0xA5C3 R=0x0F0F repeating -> locked=1 one cycle after the first left start. The following frames carry, MSB at p=1: left slot 0xA5C3, right slot 0x0F0F, p=17..31 all 0.
REQ-030 Steady stream for 10 frames -> no resync pulse; a left start always coincides with counter=63.
REQ-031 Shift input phase by 2 bck while locked -> exactly one resync pulse; subsequent frames are correct; locked stays 1.
REQ-032 Stop lj_lrck toggling -> locked falls 128 cycles after the last left start; i2s_data=0 thereafter; i2s_lrck keeps toggling every 32 bck.
REQ-033 Right channel of only 10 bits, then a left start -> the right slot repeats the previous right word 0x0F0F; no X on outputs.
REQ-034 Assert rst at counter=20 mid-stream -> all outputs 0 immediately; relock on the next left start with correct data.
